ps2_kb_rx: RTL and testbench

- System-clocked PS/2 keyboard receiver. Samples PS2_CLK/PS2_DAT asynchronously, deframes 11-bit frames with start/parity/stop checks and an inter-bit timeout, and decodes E0/F0 prefixes into make/break events.
- Events are buffered in a parametrised first-word-fall-through FIFO.
- Sits between the PS/2 pins and any consumer (text console, game logic); replaces direct PS2_CLK-clocked capture.

---
 rtl/ps2_kb_rx.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_ps2_kb_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kb_rx.sv
// ps2_kb_rx: PS/2 keyboard receiver running entirely on the system clock.
// PS2_CLK/PS2_DAT are synchronized, and falling edges of the keyboard clock
// are detected and used to deframe 11-bit frames (start, 8 data LSB first,
// odd parity, stop). An inter-edge timeout aborts stalled frames. Good bytes
// feed an E0/F0 prefix decoder. Its make/break events go into a
// first-word-fall-through FIFO.
//
// Optional build macro PS2_KB_ASCII_EN: the decoder output is translated to
// ASCII, with shift tracking. Only mapped make events are queued. When the
// macro is undefined, every decoded event is queued raw with its ext/brk flags.
//
// Handshake: VALID means the FIFO holds at least one entry, and DATA_OUT,
// IS_BREAK and IS_EXT show that head entry. A cycle with RD_EN=1 and VALID=1
// pops the head on the next rising CLK. RD_EN while VALID=0 has no effect.
// The receiver has no backpressure: an event that arrives while the FIFO is
// full is dropped, and OVERFLOW is latched.

module ps2_kb_rx #(
  parameter int CLK_HZ      = 50000000,
  parameter int TIMEOUT_US  = 2000,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic       RD_EN,
  output logic       VALID,
  output logic [7:0] DATA_OUT,
  output logic       IS_BREAK,
  output logic       IS_EXT,
  output logic       FULL,
  output logic       OVERFLOW,
  output logic       FRAME_ERR
);

  // Frame timeout in system clock cycles, plus the counter width.
  localparam int TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);
  // FIFO pointer and occupancy widths.
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int CW          = AW + 1;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    DEC_BASE,
    DEC_GOT_E0,
    DEC_GOT_F0,
    DEC_GOT_E0F0
  } dec_state_t;

  // ---------------------------------------------------------------------
  // Input synchronizers and falling-edge detect
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];
  // A fall is a synchronized 1 -> 0 change between consecutive CLK cycles.
  assign fall  = clk_prev & ~clk_s;

  // Synchronizer chains idle high, which matches the PS/2 bus at rest.
  always_ff @(posedge CLK) begin
    if (RST) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
      clk_prev <= clk_s;
    end
  end

  // ---------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------
  rx_state_t     rx_state;
  rx_state_t     rx_next;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          par_ok;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          rx_err;
  logic          byte_valid;

  // A fall resets the counter in the same cycle, so a fall always wins
  // over a timeout that would otherwise fire in that cycle.
  assign timeout = (rx_state != RX_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYC));

  // Receiver state register.
  always_ff @(posedge CLK) begin
    if (RST) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  // Receiver next state, byte delivery and error detection.
  always_comb begin
    rx_next    = rx_state;
    rx_err     = 1'b0;
    byte_valid = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (fall) begin
          if (!dat_s) rx_next = RX_SHIFT;
          else        rx_err  = 1'b1;
        end
      end
      RX_SHIFT: begin
        if (fall && bitcnt == 3'd7) rx_next = RX_PARITY;
      end
      RX_PARITY: begin
        if (fall) rx_next = RX_STOP;
      end
      RX_STOP: begin
        if (fall) begin
          rx_next = RX_IDLE;
          if (dat_s && par_ok) byte_valid = 1'b1;
          else                 rx_err     = 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
    if (timeout) begin
      rx_next = RX_IDLE;
      rx_err  = 1'b1;
    end
  end

  // Shift register, bit counter, parity result and inter-edge timer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg  <= '0;
      bitcnt <= '0;
      par_ok <= 1'b0;
      tcnt   <= '0;
    end else begin
      if (rx_state == RX_IDLE || fall) tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT_CYC)) tcnt <= tcnt + TW'(1);
      if (fall) begin
        case (rx_state)
          RX_IDLE:   bitcnt <= '0;
          RX_SHIFT: begin
            shreg  <= {dat_s, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          // Odd parity: data plus parity bit must have an odd number of ones.
          RX_PARITY: par_ok <= ^{shreg, dat_s};
          default: ;
        endcase
      end
    end
  end

  // FRAME_ERR is registered so that it is a clean single-cycle pulse.
  always_ff @(posedge CLK) begin
    if (RST) FRAME_ERR <= 1'b0;
    else     FRAME_ERR <= rx_err;
  end

  // ---------------------------------------------------------------------
  // E0/F0 prefix decoder
  // ---------------------------------------------------------------------
  dec_state_t dec_state;
  dec_state_t dec_next;
  logic       ev_valid;
  logic       ev_ext;
  logic       ev_brk;
  logic [7:0] ev_code;

  assign ev_code = shreg;

  // Decoder state register. Frame errors leave it untouched.
  always_ff @(posedge CLK) begin
    if (RST) dec_state <= DEC_BASE;
    else     dec_state <= dec_next;
  end

  // Decoder next state and event emission on each good byte.
  always_comb begin
    dec_next = dec_state;
    ev_valid = 1'b0;
    ev_ext   = 1'b0;
    ev_brk   = 1'b0;
    if (byte_valid) begin
      case (dec_state)
        DEC_BASE: begin
          if (ev_code == 8'hE0)      dec_next = DEC_GOT_E0;
          else if (ev_code == 8'hF0) dec_next = DEC_GOT_F0;
          else                       ev_valid = 1'b1;
        end
        DEC_GOT_E0: begin
          // A repeated E0 is not a prefix here; it is emitted as a code.
          if (ev_code == 8'hF0) begin
            dec_next = DEC_GOT_E0F0;
          end else begin
            ev_valid = 1'b1;
            ev_ext   = 1'b1;
            dec_next = DEC_BASE;
          end
        end
        DEC_GOT_F0: begin
          ev_valid = 1'b1;
          ev_brk   = 1'b1;
          dec_next = DEC_BASE;
        end
        DEC_GOT_E0F0: begin
          ev_valid = 1'b1;
          ev_ext   = 1'b1;
          ev_brk   = 1'b1;
          dec_next = DEC_BASE;
        end
        default: dec_next = DEC_BASE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Event to FIFO entry
  // ---------------------------------------------------------------------
  logic       push;
  logic [9:0] push_data;

`ifdef PS2_KB_ASCII_EN
  logic       lshift_held;
  logic       rshift_held;
  logic [9:0] map_res;

  // Returns {mapped, is_letter, lower-case ASCII} for a set-2 scancode.
  function automatic logic [9:0] map_key(input logic [7:0] sc);
    logic [9:0] r;
    r = '0;
    case (sc)
      8'h1C: r = {2'b11, 8'h61}; 8'h32: r = {2'b11, 8'h62};
      8'h21: r = {2'b11, 8'h63}; 8'h23: r = {2'b11, 8'h64};
      8'h24: r = {2'b11, 8'h65}; 8'h2B: r = {2'b11, 8'h66};
      8'h34: r = {2'b11, 8'h67}; 8'h33: r = {2'b11, 8'h68};
      8'h43: r = {2'b11, 8'h69}; 8'h3B: r = {2'b11, 8'h6A};
      8'h42: r = {2'b11, 8'h6B}; 8'h4B: r = {2'b11, 8'h6C};
      8'h3A: r = {2'b11, 8'h6D}; 8'h31: r = {2'b11, 8'h6E};
      8'h44: r = {2'b11, 8'h6F}; 8'h4D: r = {2'b11, 8'h70};
      8'h15: r = {2'b11, 8'h71}; 8'h2D: r = {2'b11, 8'h72};
      8'h1B: r = {2'b11, 8'h73}; 8'h2C: r = {2'b11, 8'h74};
      8'h3C: r = {2'b11, 8'h75}; 8'h2A: r = {2'b11, 8'h76};
      8'h1D: r = {2'b11, 8'h77}; 8'h22: r = {2'b11, 8'h78};
      8'h35: r = {2'b11, 8'h79}; 8'h1A: r = {2'b11, 8'h7A};
      8'h45: r = {2'b10, 8'h30}; 8'h16: r = {2'b10, 8'h31};
      8'h1E: r = {2'b10, 8'h32}; 8'h26: r = {2'b10, 8'h33};
      8'h25: r = {2'b10, 8'h34}; 8'h2E: r = {2'b10, 8'h35};
      8'h36: r = {2'b10, 8'h36}; 8'h3D: r = {2'b10, 8'h37};
      8'h3E: r = {2'b10, 8'h38}; 8'h46: r = {2'b10, 8'h39};
      8'h5A: r = {2'b10, 8'h0A}; 8'h29: r = {2'b10, 8'h20};
      8'h66: r = {2'b10, 8'h08};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Left (12) and right (59) shift are tracked separately; either one
  // held selects upper-case letters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lshift_held <= 1'b0;
      rshift_held <= 1'b0;
    end else if (ev_valid && !ev_ext) begin
      if (ev_code == 8'h12) lshift_held <= !ev_brk;
      if (ev_code == 8'h59) rshift_held <= !ev_brk;
    end
  end

  // Only non-extended makes of mapped keys produce an ASCII entry.
  always_comb begin
    map_res   = map_key(ev_code);
    push      = ev_valid && !ev_ext && !ev_brk && map_res[9];
    push_data = {2'b00, map_res[7:0]};
    if (map_res[8] && (lshift_held || rshift_held))
      push_data = {2'b00, map_res[7:0] - 8'h20};
  end
`else
  // Raw mode: every decoded event is queued with its flags.
  always_comb begin
    push      = ev_valid;
    push_data = {ev_ext, ev_brk, ev_code};
  end
`endif

  // ---------------------------------------------------------------------
  // First-word-fall-through event FIFO
  // ---------------------------------------------------------------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [9:0]    hold;
  logic [9:0]    head;
  logic          pop;
  logic          push_ok;

  assign VALID    = (cnt != '0);
  assign FULL     = (cnt == CW'(FIFO_DEPTH));
  assign pop      = RD_EN && VALID;
  // A pop in the same cycle frees a slot, so a push while full still fits.
  assign push_ok  = push && (!FULL || pop);
  // When empty, the outputs keep showing the entry popped last.
  assign head     = VALID ? mem[rptr] : hold;
  assign DATA_OUT = head[7:0];
  assign IS_BREAK = head[8];
  assign IS_EXT   = head[9];

  // Storage array write port.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wptr] <= push_data;
  end

  // Pointers, occupancy, last-popped holding register and sticky overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      hold     <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr <= rptr + AW'(1);
        hold <= mem[rptr];
      end
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (push && !push_ok) OVERFLOW <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_kb_rx.sv
// tb_ps2_kb_rx: directed bench for ps2_kb_rx. It drives PS/2 frames at
// 12.5 kHz, which is 80 cycles of the 1 MHz system clock used here, and
// checks the FIFO outputs and the FRAME_ERR pulses against hand-computed
// values.

module tb_ps2_kb_rx;

  localparam int CLK_HZ     = 1000000;
  localparam int TIMEOUT_US = 2000;
  localparam int DEPTH      = 16;
  localparam int SYNC       = 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       rd_en;
  logic       valid;
  logic [7:0] data_out;
  logic       is_break;
  logic       is_ext;
  logic       full;
  logic       overflow;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_kb_rx #(
    .CLK_HZ(CLK_HZ),
    .TIMEOUT_US(TIMEOUT_US),
    .FIFO_DEPTH(DEPTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .PS2_CLK(ps2_clk),
    .PS2_DAT(ps2_dat),
    .RD_EN(rd_en),
    .VALID(valid),
    .DATA_OUT(data_out),
    .IS_BREAK(is_break),
    .IS_EXT(is_ext),
    .FULL(full),
    .OVERFLOW(overflow),
    .FRAME_ERR(frame_err)
  );

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         errors   = 0;
  int         ferr_cnt = 0;
  int         ferr_base;
  logic [7:0] exp_q[$];

  // Counts the cycles in which FRAME_ERR is high.
  always @(posedge clk) if (frame_err) ferr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One PS/2 bit: data set up, 20 cycles, clock low for 40, high for 20.
  // With strobe set, RD_EN is raised for the cycle in which this fall
  // reaches the FIFO. That is two synchronizer stages plus the edge
  // register after the fall.
  task automatic send_bit(input logic b, input bit strobe);
    ps2_dat = b;
    repeat (20) @(negedge clk);
    ps2_clk = 1'b0;
    if (strobe) begin
      @(negedge clk);
      @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (37) @(negedge clk);
    end else begin
      repeat (40) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit strobe_stop);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i], strobe_stop && (i == 10));
    ps2_dat = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    rd_en   = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_valid", valid, 0);
    check("rst_data", data_out, 0);
    check("rst_brk", is_break, 0);
    check("rst_ext", is_ext, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);

`ifndef PS2_KB_ASCII_EN
    // Plain make code.
    ferr_base = ferr_cnt;
    send_frame(8'h1C, 0, 0);
    check("f1_valid", valid, 1);
    check("f1_data", data_out, 8'h1C);
    check("f1_brk", is_break, 0);
    check("f1_ext", is_ext, 0);
    check("f1_noerr", ferr_cnt - ferr_base, 0);
    pop_one();
    check("f1_pop_valid", valid, 0);
    check("f1_hold_data", data_out, 8'h1C);

    // Extended break: prefixes alone push nothing.
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    check("e0f0_novalid", valid, 0);
    send_frame(8'h75, 0, 0);
    check("e0f0_valid", valid, 1);
    check("e0f0_data", data_out, 8'h75);
    check("e0f0_ext", is_ext, 1);
    check("e0f0_brk", is_break, 1);
    pop_one();
    check("e0f0_single", valid, 0);

    // Parity error, then a good frame.
    ferr_base = ferr_cnt;
    send_frame(8'h1C, 1, 0);
    check("par_err_pulse", ferr_cnt - ferr_base, 1);
    check("par_nopush", valid, 0);
    send_frame(8'h32, 0, 0);
    check("par_next_valid", valid, 1);
    check("par_next_data", data_out, 8'h32);
    check("par_next_flags", {is_ext, is_break}, 0);
    pop_one();

    // Start bit of 1.
    ferr_base = ferr_cnt;
    send_bit(1'b1, 0);
    check("start_err_pulse", ferr_cnt - ferr_base, 1);

    // Timeout after 4 data bits.
    ferr_base = ferr_cnt;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    repeat (TIMEOUT_US + 10) @(negedge clk);
    check("tmo_pulse", ferr_cnt - ferr_base, 1);
    check("tmo_nopush", valid, 0);
    send_frame(8'h24, 0, 0);
    check("tmo_next_valid", valid, 1);
    check("tmo_next_data", data_out, 8'h24);
    pop_one();
    check("tmo_next_empty", valid, 0);

    // Fill the FIFO with 16 makes.
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h10 + 8'(i), 0, 0);
      exp_q.push_back(8'h10 + 8'(i));
    end
    check("fill_full", full, 1);
    check("fill_noovf", overflow, 0);
    check("fill_head", data_out, 8'h10);

    // Push and pop in the same cycle while full: accepted, no overflow.
    send_frame(8'h20, 0, 1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h20);
    check("pp_full", full, 1);
    check("pp_noovf", overflow, 0);
    check("pp_head", data_out, 8'h11);

    // Push while full without a pop: dropped.
    send_frame(8'h21, 0, 0);
    check("ovf_set", overflow, 1);
    check("ovf_full", full, 1);

    // Drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("drain%0d_valid", i), valid, 1);
      check($sformatf("drain%0d_data", i), data_out, e);
      pop_one();
    end
    check("drain_empty", valid, 0);
    check("drain_notfull", full, 0);
    check("ovf_sticky", overflow, 1);

    // Reset mid-frame discards the partial frame and clears OVERFLOW.
    send_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_ovf", overflow, 0);
    check("mrst_valid", valid, 0);
    check("mrst_data", data_out, 0);
    send_frame(8'h1C, 0, 0);
    check("mrst_next_valid", valid, 1);
    check("mrst_next_data", data_out, 8'h1C);
`else
    // ASCII mode: a, release, shift, A, shift release, a.
    send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'h12, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h12, 0, 0);
    send_frame(8'h1C, 0, 0);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h61);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("asc%0d_valid", i), valid, 1);
      check($sformatf("asc%0d_data", i), data_out, e);
      check($sformatf("asc%0d_flags", i), {is_ext, is_break}, 0);
      pop_one();
    end
    check("asc_empty", valid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
